// File: rtl/measure_pkg.sv
// Shared constants, FSM state type and seven-segment patterns for the
// measurement display path.
package measure_pkg;

  localparam int NUM_WIDTH = 14;
  localparam int DIGITS    = 5;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    SHOW,
    LOAD
  } state_t;

  // Active-low segment patterns, bit0 = a ... bit6 = g
  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_T     = 7'h07;
  localparam logic [6:0] SEG_U     = 7'h41;
  localparam logic [6:0] SEG_DASH  = 7'h3F;

  function automatic logic [6:0] mode_letter(input logic [5:0] mode);
    logic [6:0] seg;
    case (mode)
      6'd0:    seg = SEG_BLANK;
      6'd1:    seg = SEG_T;
      6'd2:    seg = SEG_U;
      default: seg = SEG_DASH;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/measure_if.sv
// Request/status bundle between the cursor-measure block and the display.
interface measure_if #(
  parameter int NUM_WIDTH = measure_pkg::NUM_WIDTH
);

  logic [NUM_WIDTH-1:0] num;
  logic [5:0]           measurement;
  logic                 update;
  logic                 busy;
  logic                 done;

  modport master (
    output num,
    output measurement,
    output update,
    input  busy,
    input  done
  );

  modport slave (
    input  num,
    input  measurement,
    input  update,
    output busy,
    output done
  );

endinterface

// File: rtl/seg7_encode.sv
// One BCD digit to active-low seven-segment pattern; codes above 9 show blank.
module seg7_encode
  import measure_pkg::*;
(
  input  logic [3:0] digit,
  input  logic       blank,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    if (!blank) begin
      case (digit)
        4'd0:    seg = SEG_0;
        4'd1:    seg = SEG_1;
        4'd2:    seg = SEG_2;
        4'd3:    seg = SEG_3;
        4'd4:    seg = SEG_4;
        4'd5:    seg = SEG_5;
        4'd6:    seg = SEG_6;
        4'd7:    seg = SEG_7;
        4'd8:    seg = SEG_8;
        4'd9:    seg = SEG_9;
        default: seg = SEG_BLANK;
      endcase
    end
  end

endmodule

// File: rtl/measure_display.sv
// Sequential double-dabble of the measurement value into registered
// seven-segment outputs, with a mode letter on hex5.
module measure_display #(
  parameter int NUM_WIDTH     = measure_pkg::NUM_WIDTH,
  parameter int DIGITS        = measure_pkg::DIGITS,
  parameter bit BLANK_LEADING = 1'b1
) (
  input  logic       clock,
  input  logic       resetn,
  measure_if.slave   bus,
  output logic [6:0] hex0,
  output logic [6:0] hex1,
  output logic [6:0] hex2,
  output logic [6:0] hex3,
  output logic [6:0] hex4,
  output logic [6:0] hex5
);

  import measure_pkg::*;

  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = $clog2(NUM_WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_SHIFT = CNT_W'(NUM_WIDTH - 1);

  state_t               state;
  state_t               state_next;
  logic [BCD_W-1:0]     bcd_q;
  logic [BCD_W-1:0]     bcd_adj;
  logic [NUM_WIDTH-1:0] bin_q;
  logic [CNT_W-1:0]     count_q;
  logic [5:0]           mode_q;
  logic                 pending_q;
  logic                 done_q;
  logic [6:0]           hex_q [6];
  logic [6:0]           seg [DIGITS];
  logic [DIGITS-1:0]    blank;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (bus.update) state_next = SHIFT;
      SHIFT:   if (count_q == LAST_SHIFT) state_next = SHOW;
      SHOW:    state_next = (pending_q || bus.update) ? LOAD : IDLE;
      LOAD:    state_next = SHIFT;
      default: state_next = IDLE;
    endcase
  end

  // Add-3 correction applied to every nibble before the shift
  always_comb begin
    bcd_adj = bcd_q;
    for (int d = 0; d < DIGITS; d++) begin
      if (bcd_q[4*d +: 4] >= 4'd5) bcd_adj[4*d +: 4] = bcd_q[4*d +: 4] + 4'd3;
    end
  end

  // A digit is blanked when it and every digit above it are zero; hex0 never
  always_comb begin
    logic seen_nonzero;
    seen_nonzero = 1'b0;
    blank        = '0;
    for (int d = DIGITS - 1; d >= 0; d--) begin
      seen_nonzero = seen_nonzero | (bcd_q[4*d +: 4] != 4'd0);
      blank[d]     = BLANK_LEADING && (d != 0) && !seen_nonzero;
    end
  end

  for (genvar g = 0; g < DIGITS; g++) begin : g_seg
    seg7_encode u_seg (
      .digit (bcd_q[4*g +: 4]),
      .blank (blank[g]),
      .seg   (seg[g])
    );
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      bcd_q     <= '0;
      bin_q     <= '0;
      count_q   <= '0;
      mode_q    <= '0;
      pending_q <= 1'b0;
      done_q    <= 1'b0;
      for (int k = 0; k < 6; k++) hex_q[k] <= SEG_BLANK;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.update) begin
            bin_q   <= bus.num;
            mode_q  <= bus.measurement;
            bcd_q   <= '0;
            count_q <= '0;
          end
        end
        SHIFT: begin
          {bcd_q, bin_q} <= {bcd_adj, bin_q} << 1;
          count_q        <= count_q + 1'b1;
          if (bus.update) pending_q <= 1'b1;
        end
        SHOW: begin
          done_q <= 1'b1;
          if (bus.update) pending_q <= 1'b1;
          if (mode_q == 6'd0) begin
            for (int k = 0; k < 6; k++) hex_q[k] <= SEG_BLANK;
          end else begin
            for (int k = 0; k < DIGITS; k++) hex_q[k] <= seg[k];
            hex_q[5] <= mode_letter(mode_q);
          end
        end
        LOAD: begin
          bin_q     <= bus.num;
          mode_q    <= bus.measurement;
          bcd_q     <= '0;
          count_q   <= '0;
          pending_q <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign bus.busy = (state != IDLE);
  assign bus.done = done_q;

  assign hex0 = hex_q[0];
  assign hex1 = hex_q[1];
  assign hex2 = hex_q[2];
  assign hex3 = hex_q[3];
  assign hex4 = hex_q[4];
  assign hex5 = hex_q[5];

endmodule
